systolic_drain: RTL

Output drain stage that sits directly downstream of the systolic controller and PE array. After the controller enters its OUT phase, this block reads the size×size accumulator matrix one row per fetch. It saturates each signed accumulator to the output width and streams the elements row-major over a val/rdy interface. When the drain finishes, it pulses done and clears the accumulators so the array can start the next LOAD.

---
 rtl/systolic_drain.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/systolic_drain.sv
// systolic_drain: reads the accumulator matrix of the PE array one row per
// fetch, saturates each signed element to the output width and streams the
// elements row-major over a val/rdy interface. When the last element has been
// accepted it pulses done together with acc_clr so the array can start its
// next LOAD phase.
module systolic_drain #(
  parameter int size      = 16,
  parameter int width     = 32,
  parameter int out_width = 16,
  localparam int iw       = (size > 1) ? $clog2(size) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  row_ren,
  output logic [iw-1:0]         row_idx,
  input  logic [size*width-1:0] row_data,
  output logic                  out_val,
  input  logic                  out_rdy,
  output logic [out_width-1:0]  out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  acc_clr,
  output logic                  sat_flag
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [iw-1:0] last_idx = iw'(size - 1);

  state_t           state;
  logic [iw-1:0]    row;
  logic [iw-1:0]    col;
  logic [iw-1:0]    col_next;
  logic [width-1:0] buf_q [size];
  logic             out_sat;
  logic             xfer;

  // Clamp a signed accumulator to the signed output range. The value is in
  // range exactly when every bit from the output sign bit upwards is equal,
  // in which case the low bits already hold the value. The returned MSB flags
  // that clamping happened; the remaining bits are the output element.
  function automatic logic [out_width:0] saturate(input logic [width-1:0] a);
    logic [width-out_width:0] upper;
    upper = a[width-1:out_width-1];
    if ((&upper) || (~|upper)) begin
      saturate = {1'b0, a[out_width-1:0]};
    end else if (a[width-1]) begin
      saturate = {1'b1, 1'b1, {(out_width-1){1'b0}}};
    end else begin
      saturate = {1'b1, 1'b0, {(out_width-1){1'b1}}};
    end
  endfunction

  assign row_idx  = row;
  assign xfer     = out_val && out_rdy;
  assign col_next = col + 1'b1;

  // Drain sequencer: every output is registered, and a stalled element keeps
  // its data, last flag and counters until the downstream accepts it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      row      <= '0;
      col      <= '0;
      row_ren  <= 1'b0;
      out_val  <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      out_sat  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      acc_clr  <= 1'b0;
      sat_flag <= 1'b0;
      for (int j = 0; j < size; j++) begin
        buf_q[j] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          done    <= 1'b0;
          acc_clr <= 1'b0;
          if (start) begin
            state    <= FETCH;
            row      <= '0;
            col      <= '0;
            row_ren  <= 1'b1;
            busy     <= 1'b1;
            sat_flag <= 1'b0;
          end
        end

        FETCH: begin
          for (int j = 0; j < size; j++) begin
            buf_q[j] <= row_data[j*width +: width];
          end
          {out_sat, out_data} <= saturate(row_data[width-1:0]);
          out_last <= (row == last_idx) && (last_idx == '0);
          out_val  <= 1'b1;
          row_ren  <= 1'b0;
          col      <= '0;
          state    <= SEND;
        end

        SEND: begin
          if (xfer) begin
            sat_flag <= sat_flag | out_sat;
            if (col != last_idx) begin
              col                 <= col_next;
              {out_sat, out_data} <= saturate(buf_q[col_next]);
              out_last            <= (row == last_idx) && (col_next == last_idx);
            end else if (row != last_idx) begin
              row      <= row + 1'b1;
              row_ren  <= 1'b1;
              out_val  <= 1'b0;
              out_last <= 1'b0;
              state    <= FETCH;
            end else begin
              out_val  <= 1'b0;
              out_last <= 1'b0;
              done     <= 1'b1;
              acc_clr  <= 1'b1;
              state    <= DONE;
            end
          end
        end

        DONE: begin
          done    <= 1'b0;
          acc_clr <= 1'b0;
          busy    <= 1'b0;
          state   <= IDLE;
        end

        default: begin
          state    <= IDLE;
          row_ren  <= 1'b0;
          out_val  <= 1'b0;
          out_last <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          acc_clr  <= 1'b0;
        end
      endcase
    end
  end

endmodule
